// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_controller
// Purpose  : Space Invaders game-state engine advanced once per frame tick;
//            drives invader row, ship, bullet and gameplay status registers.
// Revision : 1.0 - initial release
// ============================================================================
module game_controller #(
    parameter int          INVADER_PERIOD = 30,
    parameter int          BULLET_PERIOD  = 2,
    parameter int          SHIP_PERIOD    = 4,
    parameter logic [19:0] INIT_ARRAY     = 20'hFFFFF,
    parameter logic [4:0]  SHIP_START     = 5'd10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_tick,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_fire,
    output logic [19:0] o_invaders_array,
    output logic [3:0]  o_invaders_line,
    output logic [4:0]  o_ship_x,
    output logic [4:0]  o_bullet_x,
    output logic [3:0]  o_bullet_y,
    output logic        o_bullet_flying,
    output logic [1:0]  o_gameplay
);

    localparam logic [1:0] c_PLAYING   = 2'b00;
    localparam logic [1:0] c_YOU_WIN   = 2'b01;
    localparam logic [1:0] c_GAME_OVER = 2'b10;

    localparam logic [3:0] c_LOSE_LINE = 4'd13;
    localparam logic [3:0] c_FIRE_ROW  = 4'd12;
    localparam logic [4:0] c_LAST_COL  = 5'd19;

    localparam int c_IW = (INVADER_PERIOD > 1) ? $clog2(INVADER_PERIOD) : 1;
    localparam int c_BW = (BULLET_PERIOD  > 1) ? $clog2(BULLET_PERIOD)  : 1;
    localparam int c_SW = (SHIP_PERIOD    > 1) ? $clog2(SHIP_PERIOD)    : 1;

    localparam logic [c_IW-1:0] c_INV_LAST  = c_IW'(INVADER_PERIOD - 1);
    localparam logic [c_BW-1:0] c_BUL_LAST  = c_BW'(BULLET_PERIOD - 1);
    localparam logic [c_SW-1:0] c_SHIP_LAST = c_SW'(SHIP_PERIOD - 1);

    logic [19:0]     r_array;
    logic [3:0]      r_line;
    logic [4:0]      r_ship_x;
    logic [4:0]      r_bullet_x;
    logic [3:0]      r_bullet_y;
    logic            r_flying;
    logic [1:0]      r_gameplay;
    logic [c_IW-1:0] r_inv_cnt;
    logic [c_BW-1:0] r_bul_cnt;
    logic [c_SW-1:0] r_ship_cnt;

    logic w_playing;
    logic w_win;
    logic w_lose;
    logic w_inv_due;
    logic w_bul_due;
    logic w_ship_due;
    logic w_launch;
    logic w_hit;

    assign w_playing  = (r_gameplay == c_PLAYING);
    assign w_win      = (r_array == 20'd0);
    assign w_lose     = (r_line >= c_LOSE_LINE);
    assign w_inv_due  = (r_inv_cnt == c_INV_LAST);
    assign w_bul_due  = (r_bul_cnt == c_BUL_LAST);
    assign w_ship_due = (r_ship_cnt == c_SHIP_LAST);
    assign w_launch   = !r_flying && i_fire;
    assign w_hit      = r_flying && (r_bullet_y == r_line) && r_array[r_bullet_x];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_array    <= INIT_ARRAY;
            r_line     <= 4'd0;
            r_ship_x   <= SHIP_START;
            r_bullet_x <= 5'd0;
            r_bullet_y <= 4'd0;
            r_flying   <= 1'b0;
            r_gameplay <= c_PLAYING;
            r_inv_cnt  <= '0;
            r_bul_cnt  <= '0;
            r_ship_cnt <= '0;
        end else if (w_playing) begin
            // A pending end-of-game wins over any tick arriving on the same edge,
            // so the board freezes exactly as it was when the condition appeared.
            if (w_win) begin
                r_gameplay <= c_YOU_WIN;
                r_flying   <= 1'b0;
            end else if (w_lose) begin
                r_gameplay <= c_GAME_OVER;
                r_flying   <= 1'b0;
            end else if (i_tick) begin
                r_inv_cnt  <= w_inv_due  ? '0 : r_inv_cnt + 1'b1;
                r_ship_cnt <= w_ship_due ? '0 : r_ship_cnt + 1'b1;
                r_bul_cnt  <= (w_launch || w_bul_due) ? '0 : r_bul_cnt + 1'b1;

                if (w_ship_due) begin
                    if (i_left && !i_right && r_ship_x != 5'd0) begin
                        r_ship_x <= r_ship_x - 5'd1;
                    end else if (i_right && !i_left && r_ship_x != c_LAST_COL) begin
                        r_ship_x <= r_ship_x + 5'd1;
                    end
                end

                if (w_launch) begin
                    r_bullet_x <= r_ship_x;
                    r_bullet_y <= c_FIRE_ROW;
                    r_flying   <= 1'b1;
                end else if (w_hit) begin
                    r_array[r_bullet_x] <= 1'b0;
                    r_flying            <= 1'b0;
                end else if (r_flying && w_bul_due) begin
                    if (r_bullet_y != 4'd0) begin
                        r_bullet_y <= r_bullet_y - 4'd1;
                    end else begin
                        r_flying <= 1'b0;
                    end
                end

                if (w_inv_due) begin
                    r_line <= r_line + 4'd1;
                end
            end
        end
    end

    assign o_invaders_array = r_array;
    assign o_invaders_line  = r_line;
    assign o_ship_x         = r_ship_x;
    assign o_bullet_x       = r_bullet_x;
    assign o_bullet_y       = r_bullet_y;
    assign o_bullet_flying  = r_flying;
    assign o_gameplay       = r_gameplay;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_controller
// Purpose  : Self-checking bench for game_controller: three instances with
//            different invader bitmaps against a tick-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_controller;

    localparam int INV_P  = 30;
    localparam int BUL_P  = 2;
    localparam int SHIP_P = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tick  = 1'b0;
    logic left  = 1'b0;
    logic right = 1'b0;
    logic fire  = 1'b0;

    logic [19:0] arr_o  [3];
    logic [3:0]  line_o [3];
    logic [4:0]  ship_o [3];
    logic [4:0]  bx_o   [3];
    logic [3:0]  by_o   [3];
    logic        fly_o  [3];
    logic [1:0]  gp_o   [3];

    logic [19:0] c_init [3];
    assign c_init[0] = 20'hFFFFF;
    assign c_init[1] = 20'h00001;
    assign c_init[2] = 20'h00400;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    game_controller u_dut_full (
        .i_clk(clk), .i_reset(rst_n), .i_tick(tick),
        .i_left(left), .i_right(right), .i_fire(fire),
        .o_invaders_array(arr_o[0]), .o_invaders_line(line_o[0]),
        .o_ship_x(ship_o[0]), .o_bullet_x(bx_o[0]), .o_bullet_y(by_o[0]),
        .o_bullet_flying(fly_o[0]), .o_gameplay(gp_o[0])
    );

    game_controller #(.INIT_ARRAY(20'h00001)) u_dut_miss (
        .i_clk(clk), .i_reset(rst_n), .i_tick(tick),
        .i_left(left), .i_right(right), .i_fire(fire),
        .o_invaders_array(arr_o[1]), .o_invaders_line(line_o[1]),
        .o_ship_x(ship_o[1]), .o_bullet_x(bx_o[1]), .o_bullet_y(by_o[1]),
        .o_bullet_flying(fly_o[1]), .o_gameplay(gp_o[1])
    );

    game_controller #(.INIT_ARRAY(20'h00400)) u_dut_win (
        .i_clk(clk), .i_reset(rst_n), .i_tick(tick),
        .i_left(left), .i_right(right), .i_fire(fire),
        .o_invaders_array(arr_o[2]), .o_invaders_line(line_o[2]),
        .o_ship_x(ship_o[2]), .o_bullet_x(bx_o[2]), .o_bullet_y(by_o[2]),
        .o_bullet_flying(fly_o[2]), .o_gameplay(gp_o[2])
    );

    // Reference model: entity steps derived from tick counts (ticks since
    // reset for invaders/ship, ticks since launch for the bullet).
    typedef struct {
        logic [19:0] arr;
        int          line;
        int          ship;
        int          bx;
        int          by;
        bit          fly;
        int          gp;
        int          nt;
        int          nb;
    } mst_t;

    mst_t m [3];

    function automatic mst_t m_reset(input logic [19:0] init);
        mst_t n;
        n.arr = init; n.line = 0; n.ship = 10; n.bx = 0; n.by = 0;
        n.fly = 1'b0; n.gp = 0; n.nt = 0; n.nb = 0;
        return n;
    endfunction

    function automatic mst_t m_clock(input mst_t s, input bit t, input bit l,
                                     input bit r, input bit f);
        mst_t n;
        n = s;
        if (s.gp != 0) return n;
        if (s.arr == 20'd0) begin n.gp = 1; n.fly = 1'b0; return n; end
        if (s.line >= 13)   begin n.gp = 2; n.fly = 1'b0; return n; end
        if (!t) return n;
        n.nt = s.nt + 1;
        if (n.nt % SHIP_P == 0) begin
            if (l && !r)      n.ship = (s.ship > 0)  ? s.ship - 1 : 0;
            else if (r && !l) n.ship = (s.ship < 19) ? s.ship + 1 : 19;
        end
        if (!s.fly) begin
            if (f) begin n.fly = 1'b1; n.bx = s.ship; n.by = 12; n.nb = 0; end
        end else begin
            n.nb = s.nb + 1;
            if (s.by == s.line && s.arr[s.bx]) begin
                n.arr[s.bx] = 1'b0;
                n.fly = 1'b0;
            end else if (n.nb % BUL_P == 0) begin
                if (s.by > 0) n.by = s.by - 1;
                else          n.fly = 1'b0;
            end
        end
        if (n.nt % INV_P == 0) n.line = s.line + 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) m[i] <= m_reset(c_init[i]);
            else        m[i] <= m_clock(m[i], tick, left, right, fire);
        end
    end

    task automatic cmp_model(input string nm);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (arr_o[i] !== m[i].arr || line_o[i] !== 4'(m[i].line) ||
                ship_o[i] !== 5'(m[i].ship) || bx_o[i] !== 5'(m[i].bx) ||
                by_o[i] !== 4'(m[i].by) || fly_o[i] !== m[i].fly ||
                gp_o[i] !== 2'(m[i].gp)) begin
                $display("FAIL %s dut%0d: got arr=%h line=%0d ship=%0d bx=%0d by=%0d fly=%0d gp=%0d, expected arr=%h line=%0d ship=%0d bx=%0d by=%0d fly=%0d gp=%0d",
                         nm, i, arr_o[i], line_o[i], ship_o[i], bx_o[i], by_o[i], fly_o[i], gp_o[i],
                         m[i].arr, m[i].line, m[i].ship, m[i].bx, m[i].by, m[i].fly, m[i].gp);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        else passes++;
    endtask

    task automatic do_tick(input bit l, input bit r, input bit f);
        @(negedge clk);
        left = l; right = r; fire = f; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; tick = 1'b0; left = 1'b0; right = 1'b0; fire = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit l;
        bit r;
        bit f;
        int ticks;
        int exp_ship;
        int exp_line;
    } vec_t;

    vec_t vt [5];

    initial begin
        vt[0] = '{l: 1'b1, r: 1'b0, f: 1'b0, ticks: 60,  exp_ship: 0,  exp_line: 2};
        vt[1] = '{l: 1'b0, r: 1'b1, f: 1'b0, ticks: 100, exp_ship: 19, exp_line: 5};
        vt[2] = '{l: 1'b1, r: 1'b1, f: 1'b0, ticks: 20,  exp_ship: 19, exp_line: 6};
        vt[3] = '{l: 1'b1, r: 1'b0, f: 1'b0, ticks: 8,   exp_ship: 17, exp_line: 6};
        vt[4] = '{l: 1'b0, r: 1'b0, f: 1'b0, ticks: 12,  exp_ship: 17, exp_line: 6};

        // Reset held while ticks toggle: nothing may move.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tick = ~tick; left = 1'b1; fire = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0; left = 1'b0; fire = 1'b0;
        check("reset_array", int'(arr_o[0]), 32'hFFFFF);
        check("reset_line", int'(line_o[0]), 0);
        check("reset_ship", int'(ship_o[0]), 10);
        check("reset_flying", int'(fly_o[0]), 0);
        check("reset_gameplay", int'(gp_o[0]), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("release_hold_ship", int'(ship_o[0]), 10);
        cmp_model("release_hold");

        // Launch on the first tick; bullet climbs, hits column 10 / misses.
        do_tick(1'b0, 1'b0, 1'b1);
        check("launch_flying", int'(fly_o[1]), 1);
        check("launch_x", int'(bx_o[1]), 10);
        check("launch_y", int'(by_o[1]), 12);
        repeat (24) do_tick(1'b0, 1'b0, 1'b0);
        check("climb_y0", int'(by_o[1]), 0);
        check("climb_still_flying", int'(fly_o[1]), 1);
        cmp_model("climb");
        do_tick(1'b0, 1'b0, 1'b0);
        check("hit_array", int'(arr_o[0]), 32'hFFBFF);
        check("hit_flying", int'(fly_o[0]), 0);
        check("hit_line", int'(line_o[0]), 0);
        check("win_array_empty", int'(arr_o[2]), 0);
        check("miss_not_yet", int'(fly_o[1]), 1);
        @(negedge clk);
        check("win_gameplay", int'(gp_o[2]), 1);
        do_tick(1'b0, 1'b0, 1'b0);
        check("miss_flying", int'(fly_o[1]), 0);
        check("miss_array", int'(arr_o[1]), 1);
        check("miss_y_hold", int'(by_o[1]), 0);
        cmp_model("miss");
        repeat (3) do_tick(1'b0, 1'b0, 1'b1);
        check("win_no_launch", int'(fly_o[2]), 0);
        check("win_terminal", int'(gp_o[2]), 1);
        cmp_model("win_frozen");

        // Table-driven ship movement; line descends in the background.
        do_reset();
        for (int v = 0; v < 5; v++) begin
            repeat (vt[v].ticks) do_tick(vt[v].l, vt[v].r, vt[v].f);
            check($sformatf("vec%0d_ship", v), int'(ship_o[0]), vt[v].exp_ship);
            check($sformatf("vec%0d_line", v), int'(line_o[0]), vt[v].exp_line);
            cmp_model($sformatf("vec%0d", v));
        end

        // Idle to tick 390: line 13, then game over one clock later.
        repeat (189) do_tick(1'b0, 1'b0, 1'b0);
        check("pre_over_line", int'(line_o[0]), 12);
        do_tick(1'b0, 1'b0, 1'b0);
        check("over_line", int'(line_o[0]), 13);
        check("over_pending", int'(gp_o[0]), 0);
        @(negedge clk);
        check("over_gameplay", int'(gp_o[0]), 2);
        repeat (40) do_tick(1'b1, 1'b0, 1'b1);
        check("over_line_sat", int'(line_o[0]), 13);
        check("over_ship_frozen", int'(ship_o[0]), 17);
        check("over_no_fire", int'(fly_o[0]), 0);
        check("over_terminal", int'(gp_o[0]), 2);
        cmp_model("over_frozen");

        // Randomized play with occasional asynchronous resets.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            rst_n = !((c % 1500 == 0) || ($urandom_range(0, 599) == 0));
            tick  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) left  = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) right = $urandom_range(0, 1);
            fire = ($urandom_range(0, 3) == 0);
            #1;
            cmp_model("random");
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
